// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for uart_tx_arbiter (HDR state exists only with UART_ARB_HEADER_EN)
package uart_pkg;
  localparam int UART_ARB_MAX_REQ = 16;
  localparam logic [3:0] UART_ARB_HDR_TAG = 4'hA;
  typedef enum logic [2:0] {
    ARB,
    SEND,
    ISSUE,
    WAIT_START,
    WAIT_DONE
`ifdef UART_ARB_HEADER_EN
    , HDR
`endif
  } uart_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin picker starting the search at ptr_i
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] lo, hi;
  logic          hit;
  // lowest request at or above ptr wins; otherwise wrap to the lowest request overall
  always_comb begin
    lo  = '0;
    hi  = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) lo = IW'(i);
      if (req_i[i] && i >= int'(ptr_i)) begin
        hi  = IW'(i);
        hit = 1'b1;
      end
    end
    idx_o = hit ? hi : lo;
    gnt_o = (|req_i) ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART transmitter; UART_ARB_HEADER_EN prefixes each packet with {A,id}
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_data_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               err_clr,
  output logic               timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT);

  uart_arb_state_t  state_q;
  logic [IW-1:0]    ptr_q, gidx_q, pick_idx, ptr_nxt;
  logic [N_REQ-1:0] grant_q, pick_gnt;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       tx_data_q;
  logic             last_q, tx_data_valid_q, timeout_err_q;
  logic             accept, tmo, done;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign accept        = state_q == SEND && !tx_busy && req_valid[gidx_q];
  assign req_ready     = accept ? grant_q : '0;
  assign tmo           = state_q == WAIT_START && !tx_busy && cnt_q == CW'(START_TIMEOUT - 1);
  assign done          = (state_q == WAIT_DONE && !tx_busy) || tmo;
  assign ptr_nxt       = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
  assign grant         = grant_q;
  assign tx_data_valid = tx_data_valid_q;
  assign tx_data       = tx_data_q;
  assign timeout_err   = timeout_err_q;

  // arbitration FSM; the start counter is zeroed as a byte is issued so it counts cycles since tx_data_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ARB;
      ptr_q           <= '0;
      gidx_q          <= '0;
      grant_q         <= '0;
      tx_data_valid_q <= 1'b0;
      tx_data_q       <= '0;
      timeout_err_q   <= 1'b0;
      last_q          <= 1'b0;
      cnt_q           <= '0;
    end else begin
      tx_data_valid_q <= 1'b0;
      cnt_q           <= (&cnt_q) ? cnt_q : cnt_q + CW'(1);
      timeout_err_q   <= tmo ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
      case (state_q)
        ARB: if (|req_valid) begin
          grant_q <= pick_gnt;
          gidx_q  <= pick_idx;
`ifdef UART_ARB_HEADER_EN
          state_q <= HDR;
`else
          state_q <= SEND;
`endif
        end
`ifdef UART_ARB_HEADER_EN
        HDR: begin
          tx_data_q       <= {UART_ARB_HDR_TAG, 4'(gidx_q)};
          last_q          <= 1'b0;
          cnt_q           <= '0;
          tx_data_valid_q <= 1'b1;
          state_q         <= ISSUE;
        end
`endif
        SEND: if (accept) begin
          tx_data_q       <= req_data[{gidx_q, 3'b000} +: 8];
          last_q          <= req_last[gidx_q];
          cnt_q           <= '0;
          tx_data_valid_q <= 1'b1;
          state_q         <= ISSUE;
        end
        ISSUE: state_q <= WAIT_START;
        default: if (state_q == WAIT_START && tx_busy) state_q <= WAIT_DONE;
        else if (done) begin
          if (last_q) begin
            ptr_q   <= ptr_nxt;
            grant_q <= '0;
            state_q <= ARB;
          end else state_q <= SEND;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (header expectations follow UART_ARB_HEADER_EN)
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int N    = 2;
  localparam int TMO  = 16;
  localparam int BUSY = 10;
`ifdef UART_ARB_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif
  logic        clk = 0, rst = 1, tx_busy = 0, err_clr = 0;
  logic [1:0]  req_valid = 0, req_last = 0, req_ready, grant;
  logic [15:0] req_data = 0;
  logic        tx_data_valid, timeout_err;
  logic [7:0]  tx_data;
  logic [8:0]  q0[$], q1[$];
  logic [7:0]  exp_q[$];
  int          checks = 0, failures = 0, cyc = 0, acc_cyc = 0, vcyc = 0, n_tx = 0, bcnt = 0, rdy1 = 0, v = 0;
  logic        acc_p = 0, hold0 = 0, mute = 0, start_s = 0;
  logic [1:0]  r_s = 0;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .tx_busy(tx_busy), .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (r_s[0] && q0.size() != 0) void'(q0.pop_front());
    if (r_s[1] && q1.size() != 0) void'(q1.pop_front());
    if (start_s && !mute) bcnt = BUSY;
    tx_busy = bcnt != 0;
    if (bcnt != 0) bcnt--;
    req_valid[0] = q0.size() != 0 && !hold0;
    {req_last[0], req_data[7:0]} = q0.size() != 0 ? q0[0] : 9'h0;
    req_valid[1] = q1.size() != 0;
    {req_last[1], req_data[15:8]} = q1.size() != 0 ? q1[0] : 9'h0;
    @(negedge clk);
    cyc++;
    if (|req_ready) begin
      chk("ready_onehot", 32'($onehot(req_ready)), 1);
      acc_cyc = cyc;
      acc_p   = 1;
      if (req_ready[1]) rdy1++;
    end
    if (tx_data_valid) begin
      chk("valid_single_cycle", 32'(start_s), 0);
      n_tx++;
      vcyc = cyc;
      chk("tx_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      if (acc_p) begin
        chk("accept_to_valid", cyc, acc_cyc + 1);
        acc_p = 0;
      end
    end
    r_s     = req_ready;
    start_s = tx_data_valid;
  endtask

  task automatic do_reset();
    rst = 1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    bcnt  = 0;
    hold0 = 0;
    mute  = 0;
    tick();
    tick();
    rst   = 0;
    n_tx  = 0;
    acc_p = 0;
    rdy1  = 0;
  endtask

  task automatic pkt(input int id, input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] b;
`ifdef UART_ARB_HEADER_EN
    exp_q.push_back({4'hA, 4'(id)});
`endif
    for (int k = 0; k < n; k++) begin
      b = k == 0 ? b0 : (k == 1 ? b1 : b2);
      if (id == 0) q0.push_back({k == n - 1, b});
      else q1.push_back({k == n - 1, b});
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && grant == 2'b00 && !tx_busy) && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < 2000), 1);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (n_tx < n && k < 500) begin
      tick();
      k++;
    end
    chk(tag, 32'(n_tx >= n), 1);
  endtask

  initial begin
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(tx_data_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ptr", 32'(dut.ptr_q), 0);

    pkt(0, 1, 8'h55, 8'h00, 8'h00);
    drain("single_drain");
    chk("single_grant", 32'(grant), 0);
    chk("single_ptr", 32'(dut.ptr_q), 1);

    do_reset();
    pkt(0, 1, 8'h11, 8'h00, 8'h00);
    pkt(1, 1, 8'h22, 8'h00, 8'h00);
    pkt(0, 1, 8'h11, 8'h00, 8'h00);
    pkt(1, 1, 8'h22, 8'h00, 8'h00);
    drain("fair_drain");

    do_reset();
    pkt(0, 3, 8'hA1, 8'hA2, 8'hA3);
    pkt(1, 1, 8'hB1, 8'h00, 8'h00);
    wait_tx(HB + 1, "lock_first");
    hold0 = 1;
    repeat (20) tick();
    chk("lock_grant", 32'(grant), 1);
    chk("lock_no_tx", n_tx, HB + 1);
    hold0 = 0;
    drain("lock_drain");

    do_reset();
    mute = 1;
    pkt(0, 2, 8'hC1, 8'hC2, 8'h00);
    wait_tx(1, "tmo_first");
    v = vcyc;
    while (cyc < v + 15) tick();
    chk("tmo_early", 32'(timeout_err), 0);
    tick();
    chk("tmo_set", 32'(timeout_err), 1);
    drain("tmo_drain");
    chk("tmo_sticky", 32'(timeout_err), 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("tmo_clear", 32'(timeout_err), 0);
    mute = 0;

    do_reset();
    pkt(0, 3, 8'hD1, 8'hD2, 8'hD3);
    wait_tx(HB + 2, "mid_wait");
    repeat (3) tick();
    chk("mid_grant", 32'(grant), 1);
    chk("mid_state", 32'(dut.state_q), 32'(WAIT_DONE));
    rst = 1;
    q0.delete();
    exp_q.delete();
    tick();
    rst = 0;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_valid", 32'(tx_data_valid), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_err", 32'(timeout_err), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ARB));
    chk("mid_rst_ptr", 32'(dut.ptr_q), 0);
    pkt(1, 1, 8'hE1, 8'h00, 8'h00);
    drain("mid_req1");
    chk("mid_req1_ptr", 32'(dut.ptr_q), 0);

`ifdef UART_ARB_HEADER_EN
    do_reset();
    pkt(1, 1, 8'h7E, 8'h00, 8'h00);
    drain("hdr_drain");
    chk("hdr_ready_once", rdy1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `N_REQ` byte-stream requesters with packet-level locking and round-robin fairness. The block sits between the requesters and the transmitter's `tx_data_valid`/`tx_data`/`tx_busy` interface. It sequences exactly one byte at a time into the transmitter and supervises the transmitter's busy handshake with a start timeout.

## Interface
- `N_REQ`, default 2: number of requesters, 2..16.
- `START_TIMEOUT`, default 64: cycles allowed between issuing a byte and seeing `tx_busy` rise, ≥ 2.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req_valid` input N_REQ: requester i has a byte.
- `req_data` input N_REQ*8: byte of requester i at bits [8i+7:8i].
- `req_last` input N_REQ: byte of requester i is the last of its packet.
- `req_ready` output N_REQ: one-hot accept pulse, combinational.
- `grant` output N_REQ: one-hot owner of the transmitter, registered.
- `tx_data_valid` output 1: one-cycle issue pulse to the transmitter, registered.
- `tx_data` output 8: byte to transmit, registered.
- `tx_busy` input 1: transmitter busy.
- `err_clr` input 1: clears `timeout_err`.
- `timeout_err` output 1: sticky flag; `tx_busy` did not rise within `START_TIMEOUT` cycles.

## Operation
- States: ARB, HDR (macro only), SEND, ISSUE, WAIT_START, WAIT_DONE.
- **ARB**
  - If any `req_valid`: pick the first set bit at or after the round-robin pointer `ptr`, wrapping modulo N_REQ.
  - Register `grant`. Go to HDR or SEND.
  - If no request: stay in ARB with `grant`=0.
- **SEND**
  - If `tx_busy`=0 and `req_valid[g]`=1: assert `req_ready[g]` this cycle.
  - Capture `req_data[g]` into `tx_data` and `req_last[g]` into `last_q`. Go to ISSUE.
  - Otherwise wait. Other requesters are not served; the packet lock holds.
- **ISSUE**: `tx_data_valid`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_START.
- **WAIT_START**
  - If `tx_busy`=1: go to WAIT_DONE.
  - If the counter reaches `START_TIMEOUT`-1 with no busy: set `timeout_err` and treat the byte as sent, following the WAIT_DONE exit rules immediately.
- **WAIT_DONE**: when `tx_busy`=0:
  - If `last_q` is set: `ptr` ← g+1 mod N_REQ, clear `grant`, go to ARB.
  - Otherwise go to SEND.
  - A header byte never counts as last.
- **Priority**: `timeout_err` set wins over `err_clr` in the same cycle.
- **Reset** (any state, including mid-packet):
  - State goes to ARB; `ptr` = 0.
  - `grant`, `req_ready`, `tx_data_valid`, `tx_data`, `timeout_err`, `last_q` and the counter all go to 0.
- The counter is $clog2(START_TIMEOUT) bits wide and saturates; it never wraps.

## Timing
- Request accepted at cycle T gives `tx_data_valid` at T+1.
- Minimum ARB-to-first-accept latency: 1 cycle, or 1 cycle plus a header byte when the macro is compiled in.
- Fastest byte-to-byte: one ISSUE, at least one WAIT_START cycle, the transmitter busy period, then SEND.
- `req_ready` is high only in SEND, with `tx_busy`=0 and `req_valid[g]`=1. At most one bit is high.
- `req_valid[g]` dropping mid-packet is legal: the arbiter waits in SEND indefinitely.
- A requester whose `req_valid` is low in ARB is skipped. The pointer does not advance until a packet completes.

## Configuration
- `UART_ARB_HEADER_EN` defined:
  - ARB goes to HDR, which loads `tx_data` = {4'hA, id[3:0]} (id = granted index) and goes to ISSUE.
  - After the header's WAIT_DONE, go to SEND.
  - `req_ready` is not asserted for the header.
- Not defined: HDR does not exist; packets are sent raw.

## Structure
- In `uart_pkg`:
  - the state enum typedef `uart_arb_state_t`;
  - the header nibble constant `UART_ARB_HDR_TAG` = 4'hA;
  - the max-requester constant `UART_ARB_MAX_REQ` = 16.
- Sub-module `rr_arbiter`: combinational one-hot round-robin picker. Inputs are the request vector and `ptr`; outputs are the one-hot grant and its binary index.

## Test plan
- **Single byte**: N_REQ=2. Req0 sends 8'h55 with last=1 and the bench transmitter model runs busy for 10 cycles.
  - `tx_data` = 8'h55, `tx_data_valid` one cycle at T+1 after `req_ready[0]`.
  - `grant` returns to 0 and `ptr` = 1.
- **Fairness**: both requesters continuously send single-byte packets (0x11 and 0x22).
  - `tx_data` alternates 11,22,11,22; neither requester is served twice in a row.
- **Packet lock**: req0 sends 3-byte packet A1,A2,A3 (last on A3) while req1 is valid throughout.
  - All three A-bytes go out before any req1 byte.
  - Req0 drops valid for 20 cycles mid-packet: the grant holds and no req1 byte is sent.
- **Timeout**: START_TIMEOUT=16 and the transmitter model never raises busy.
  - `timeout_err` rises 16 cycles after `tx_data_valid`; the next byte is still served.
  - `err_clr` clears the flag.
- **Reset mid-packet**: assert `rst` during WAIT_DONE of byte 2 of 3.
  - Next cycle: all outputs 0, state ARB, `ptr` 0.
  - A new req1 packet is served first if only req1 is valid.
- **Header** (with `UART_ARB_HEADER_EN`): req1 sends packet 0x7E with last=1.
  - Transmitted sequence: 0xA1 then 0x7E.
  - `req_ready[1]` pulses exactly once.
